// File: rtl/vic_regs.sv
// rtl/vic_regs.sv - VIC register file with vblank-latched decoded video outputs
//
// CPU-visible 16-byte register window at BASE..BASE+15 with one-cycle read
// latency, plus registered decodes of the screen/character/colour-RAM bases
// and colour settings for the pixel generator.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   cpu_addr/din      CPU address and write data
//   cpu_we/cpu_re     single-cycle write / read strobes
//   cpu_dout/cpu_sel  read data and data-mux select, valid the cycle after cpu_re
//   raster_line       live raster line, returned through regs 3 and 4
//   vblank            single-cycle pulse at start of vertical blank
//   screen_addr, char_rom_addr, color_ram_addr, border_color, back_color,
//   inverted, aux_color   decoded video settings

module vic_regs #(
  parameter logic [15:0] BASE         = 16'h9000,
  parameter bit          VBLANK_LATCH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_dout,
  output logic        cpu_sel,
  input  logic [8:0]  raster_line,
  input  logic        vblank,
  output logic [15:0] screen_addr,
  output logic [15:0] char_rom_addr,
  output logic [15:0] color_ram_addr,
  output logic [2:0]  border_color,
  output logic [3:0]  back_color,
  output logic        inverted,
  output logic [3:0]  aux_color
);

  localparam logic [7:0] RST2 = 8'h96;
  localparam logic [7:0] RST3 = 8'hAE;
  localparam logic [7:0] RST5 = 8'hF0;
  localparam logic [7:0] RSTE = 8'h00;
  localparam logic [7:0] RSTF = 8'h1B;

  function automatic logic [7:0] reset_value(input logic [3:0] i);
    case (i)
      4'h2:    return RST2;
      4'h3:    return RST3;
      4'h5:    return RST5;
      4'hE:    return RSTE;
      4'hF:    return RSTF;
      default: return 8'h00;
    endcase
  endfunction

  // Codes 0-7 select 1 KiB blocks from $8000 upward; codes 8-15 wrap to $0000.
  function automatic logic [15:0] block_addr(input logic [3:0] c);
    logic [15:0] off;
    off = {3'b000, c[2:0], 10'b0};
    return c[3] ? off : (16'h8000 + off);
  endfunction

  function automatic logic [15:0] dec_screen(input logic [7:0] r5, input logic [7:0] r2);
    return block_addr(r5[7:4]) | {6'b0, r2[7], 9'b0};
  endfunction

  function automatic logic [15:0] dec_color_ram(input logic [7:0] r2);
    return r2[7] ? 16'h9600 : 16'h9400;
  endfunction

  logic [7:0] regs [16];
  logic       hit;
  logic [3:0] idx;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rd_data;

  assign hit   = (cpu_addr[15:4] == BASE[15:4]);
  assign idx   = cpu_addr[3:0];
  assign wr_en = cpu_we && hit;
  assign rd_en = cpu_re && hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= reset_value(4'(i));
      end
    end else if (wr_en) begin
      regs[idx] <= cpu_din;
    end
  end

  // Read mux works from the pre-write contents, so a same-cycle write to the
  // same register is not visible to the read.
  always_comb begin
    rd_data = regs[idx];
    case (idx)
      4'h3:       rd_data = {raster_line[0], regs[3][6:0]};
      4'h4:       rd_data = raster_line[8:1];
      4'h6, 4'h7: rd_data = 8'h00;
      4'h8, 4'h9: rd_data = 8'hFF;
      default:    rd_data = regs[idx];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_dout <= 8'h00;
      cpu_sel  <= 1'b0;
    end else begin
      cpu_sel <= rd_en;
      if (rd_en) begin
        cpu_dout <= rd_data;
      end
    end
  end

  // Register values as they will stand after this edge, so a write landing
  // on the vblank cycle is captured by the latch.
  logic [7:0] nxt2;
  logic [7:0] nxt5;
  logic [7:0] nxte;
  logic [7:0] nxtf;
  logic       load;

  assign nxt2 = (wr_en && idx == 4'h2) ? cpu_din : regs[2];
  assign nxt5 = (wr_en && idx == 4'h5) ? cpu_din : regs[5];
  assign nxte = (wr_en && idx == 4'hE) ? cpu_din : regs[14];
  assign nxtf = (wr_en && idx == 4'hF) ? cpu_din : regs[15];
  assign load = VBLANK_LATCH ? vblank : 1'b1;

  // The decoded output registers double as the shadow latch: they load only
  // on vblank (or every cycle when latching is disabled), so a mid-frame
  // write never tears the picture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      screen_addr    <= dec_screen(RST5, RST2);
      char_rom_addr  <= block_addr(RST5[3:0]);
      color_ram_addr <= dec_color_ram(RST2);
      border_color   <= RSTF[2:0];
      back_color     <= RSTF[7:4];
      inverted       <= ~RSTF[3];
      aux_color      <= RSTE[7:4];
    end else if (load) begin
      screen_addr    <= dec_screen(nxt5, nxt2);
      char_rom_addr  <= block_addr(nxt5[3:0]);
      color_ram_addr <= dec_color_ram(nxt2);
      border_color   <= nxtf[2:0];
      back_color     <= nxtf[7:4];
      inverted       <= ~nxtf[3];
      aux_color      <= nxte[7:4];
    end
  end

endmodule

// File: tb/tb_vic_regs.sv
// tb/tb_vic_regs.sv - table-driven and scoreboard bench for vic_regs

module tb_vic_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_re;
  logic [8:0]  raster_line;
  logic        vblank;

  logic [7:0]  dout0, dout1;
  logic        sel0, sel1;
  logic [15:0] screen0, screen1, char0, char1, color0, color1;
  logic [2:0]  border0, border1;
  logic [3:0]  back0, back1, aux0, aux1;
  logic        inv0, inv1;

  always #5 clk = ~clk;

  vic_regs #(.BASE(16'h9000), .VBLANK_LATCH(1'b1)) u_latch (
    .clk(clk), .reset(rst_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_dout(dout0), .cpu_sel(sel0),
    .raster_line(raster_line), .vblank(vblank), .screen_addr(screen0),
    .char_rom_addr(char0), .color_ram_addr(color0), .border_color(border0),
    .back_color(back0), .inverted(inv0), .aux_color(aux0)
  );

  vic_regs #(.BASE(16'h9000), .VBLANK_LATCH(1'b0)) u_live (
    .clk(clk), .reset(rst_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_dout(dout1), .cpu_sel(sel1),
    .raster_line(raster_line), .vblank(vblank), .screen_addr(screen1),
    .char_rom_addr(char1), .color_ram_addr(color1), .border_color(border1),
    .back_color(back1), .inverted(inv1), .aux_color(aux1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    bit          re;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [8:0]  raster;
    logic [7:0]  exp_dout;
    bit          exp_sel;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    bit         sel;
    int         id;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sbq[$];
  logic [7:0] model_dout;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit we, input bit re, input logic [15:0] addr,
                     input logic [7:0] din, input logic [8:0] raster,
                     input logic [7:0] exp_dout, input bit exp_sel);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.din = din;
    v.raster = raster; v.exp_dout = exp_dout; v.exp_sel = exp_sel;
    vecs.push_back(v);
  endtask

  // One bus cycle: drive after the falling edge, sample 1 ns after the rising edge.
  task automatic drive(input bit we, input bit re, input bit vb, input logic [15:0] addr,
                       input logic [7:0] din, input logic [8:0] raster,
                       input logic [7:0] exp_dout, input bit exp_sel, input int id);
    sb_t e;
    @(negedge clk);
    cpu_we = we; cpu_re = re; vblank = vb;
    cpu_addr = addr; cpu_din = din; raster_line = raster;
    if (exp_sel) model_dout = exp_dout;
    sbq.push_back('{model_dout, exp_sel, id});
    @(posedge clk);
    #1;
    cpu_we = 1'b0; cpu_re = 1'b0; vblank = 1'b0;
    e = sbq.pop_front();
    chk($sformatf("cyc%0d_dout", e.id), {8'h00, dout0}, {8'h00, e.dout});
    chk($sformatf("cyc%0d_sel", e.id), {15'h0, sel0}, {15'h0, e.sel});
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] din, input bit vb, input int id);
    drive(1'b1, 1'b0, vb, addr, din, 9'h000, 8'h00, 1'b0, id);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [7:0] exp, input int id);
    drive(1'b0, 1'b1, 1'b0, addr, 8'h00, 9'h000, exp, 1'b1, id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cpu_addr = 16'h0000; cpu_din = 8'h00;
    cpu_we = 1'b0; cpu_re = 1'b0; raster_line = 9'h000; vblank = 1'b0;
    model_dout = 8'h00;

    //   we  re  addr      din    raster  dout   sel
    add(0, 1, 16'h900F, 8'h00, 9'h000, 8'h1B, 1);
    add(0, 1, 16'h9004, 8'h00, 9'h12B, 8'h95, 1);
    add(0, 1, 16'h9003, 8'h00, 9'h12B, 8'hAE, 1);
    add(0, 1, 16'h9003, 8'h00, 9'h12A, 8'h2E, 1);
    add(0, 1, 16'h9008, 8'h00, 9'h000, 8'hFF, 1);
    add(0, 1, 16'h9009, 8'h00, 9'h000, 8'hFF, 1);
    add(0, 1, 16'h9006, 8'h00, 9'h000, 8'h00, 1);
    add(0, 1, 16'h9007, 8'h00, 9'h000, 8'h00, 1);
    add(1, 0, 16'h9004, 8'h55, 9'h000, 8'h00, 0);
    add(0, 1, 16'h9004, 8'h00, 9'h000, 8'h00, 1);
    add(1, 0, 16'h9000, 8'hA5, 9'h000, 8'h00, 0);
    add(0, 1, 16'h9000, 8'h00, 9'h000, 8'hA5, 1);
    add(1, 1, 16'h9001, 8'h3C, 9'h000, 8'h00, 1);
    add(0, 1, 16'h9001, 8'h00, 9'h000, 8'h3C, 1);
    add(1, 0, 16'h9010, 8'h77, 9'h000, 8'h00, 0);
    add(0, 1, 16'h9010, 8'h00, 9'h000, 8'h00, 0);
    add(1, 0, 16'h8FFF, 8'h77, 9'h000, 8'h00, 0);
    add(0, 1, 16'h8FFF, 8'h00, 9'h000, 8'h00, 0);
    add(0, 1, 16'h9000, 8'h00, 9'h000, 8'hA5, 1);
    add(0, 1, 16'h900F, 8'h00, 9'h000, 8'h1B, 1);
    add(1, 0, 16'h9003, 8'hFF, 9'h000, 8'h00, 0);
    add(0, 1, 16'h9003, 8'h00, 9'h000, 8'h7F, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_screen", screen0, 16'h1E00);
    chk("rst_char", char0, 16'h8000);
    chk("rst_color", color0, 16'h9600);
    chk("rst_border", {13'h0, border0}, 16'h0003);
    chk("rst_back", {12'h0, back0}, 16'h0001);
    chk("rst_inv", {15'h0, inv0}, 16'h0000);
    chk("rst_aux", {12'h0, aux0}, 16'h0000);
    chk("rst_dout", {8'h00, dout0}, 16'h0000);
    chk("rst_sel", {15'h0, sel0}, 16'h0000);
    chk("rst_screen_live", screen1, 16'h1E00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].re, 1'b0, vecs[i].addr, vecs[i].din,
            vecs[i].raster, vecs[i].exp_dout, vecs[i].exp_sel, i);
    end

    // Mid-frame writes stay hidden until vblank on the latched instance.
    wr(16'h9005, 8'hC2, 1'b0, 100);
    wr(16'h9002, 8'h16, 1'b0, 101);
    chk("midframe_screen", screen0, 16'h1E00);
    chk("midframe_char", char0, 16'h8000);
    chk("midframe_color", color0, 16'h9600);
    chk("live_screen", screen1, 16'h1000);
    chk("live_char", char1, 16'h8800);
    chk("live_color", color1, 16'h9400);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 9'h000, 8'h00, 1'b0, 102);
    chk("vb_screen", screen0, 16'h1000);
    chk("vb_char", char0, 16'h8800);
    chk("vb_color", color0, 16'h9400);

    // Write coinciding with vblank is captured.
    wr(16'h900F, 8'h08, 1'b1, 103);
    chk("same_back", {12'h0, back0}, 16'h0000);
    chk("same_border", {13'h0, border0}, 16'h0000);
    chk("same_inv", {15'h0, inv0}, 16'h0000);
    wr(16'h900F, 8'h00, 1'b0, 104);
    chk("hold_inv", {15'h0, inv0}, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 9'h000, 8'h00, 1'b0, 105);
    chk("vb_inv", {15'h0, inv0}, 16'h0001);

    // Asynchronous reset mid-cycle, with a read pending.
    wr(16'h900E, 8'hA0, 1'b0, 106);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 9'h000, 8'h00, 1'b0, 107);
    chk("aux_set", {12'h0, aux0}, 16'h000A);
    @(negedge clk);
    cpu_addr = 16'h900E; cpu_re = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_aux", {12'h0, aux0}, 16'h0000);
    chk("arst_aux_live", {12'h0, aux1}, 16'h0000);
    chk("arst_screen", screen0, 16'h1E00);
    chk("arst_inv", {15'h0, inv0}, 16'h0000);
    chk("arst_dout", {8'h00, dout0}, 16'h0000);
    @(posedge clk);
    #1;
    chk("arst_sel_dropped", {15'h0, sel0}, 16'h0000);
    cpu_re = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_dout = 8'h00;
    rd(16'h900E, 8'h00, 108);
    rd(16'h900F, 8'h1B, 109);

    // Unlatched instance follows a write one cycle later.
    wr(16'h900E, 8'h70, 1'b0, 110);
    chk("live_aux", {12'h0, aux1}, 16'h0007);
    chk("latched_aux_hold", {12'h0, aux0}, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 9'h000, 8'h00, 1'b0, 111);
    chk("latched_aux_vb", {12'h0, aux0}, 16'h0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
